// File: rtl/char_pixel_serializer.sv
// Glyph-byte serializer for the Galaksija video path: picks the ROM or patch byte,
// buffers it in a one-byte holding register and shifts it out one pixel per pix_ce.
// Ports: clk/reset; pix_ce pixel enable; rom_q/patch_q/patch byte select;
//   char_valid/char_ready byte handshake; flush line-start flush; blank/invert pixel
//   modifiers; pixel registered serial output; overrun/underrun sticky debug flags
//   cleared by clr_err.
module char_pixel_serializer #(
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_PIXEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_ce,
  input  logic [7:0] rom_q,
  input  logic [7:0] patch_q,
  input  logic       patch,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       flush,
  input  logic       blank,
  input  logic       invert,
  output logic       pixel,
  output logic       overrun,
  output logic       underrun,
  input  logic       clr_err
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t     state, state_nxt;
  logic [7:0] hold, shreg;
  logic       hold_full;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] din;

  // Output-decode results
  logic       xfer;      // hold register moves into the shifter this cycle
  logic       emit;      // a data bit is emitted this cycle
  logic       emit_bit;  // the raw data bit being emitted
  logic       starve;    // pix_ce with nothing to emit

  logic       capture, drop;
  logic       hold_full_nxt;

  // patch_q is only looked at when patch is high, so an undriven patch bus is harmless.
  assign din = patch ? patch_q : rom_q;

  function automatic logic pick(input logic [7:0] b, input logic [2:0] i);
    return LSB_FIRST ? b[i] : b[3'd7 - i];
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else if (pix_ce) begin
      case (state)
        IDLE:    if (hold_full) state_nxt = SHIFT;
        SHIFT:   if (cnt == 3'd7 && !hold_full) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: what happens on this pixel enable
  always_comb begin
    xfer     = 1'b0;
    emit     = 1'b0;
    emit_bit = 1'b0;
    starve   = 1'b0;
    cnt_nxt  = cnt;
    if (pix_ce) begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            // First bit comes straight from the holding register.
            xfer     = 1'b1;
            emit     = 1'b1;
            emit_bit = pick(hold, 3'd0);
            cnt_nxt  = 3'd1;
          end else begin
            starve   = 1'b1;
          end
        end
        SHIFT: begin
          emit     = 1'b1;
          emit_bit = pick(shreg, cnt);
          // Wraps 7 -> 0, which is both the gapless restart and the idle value.
          cnt_nxt  = cnt + 3'd1;
          if (cnt == 3'd7 && hold_full) xfer = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign capture       = char_valid && (!hold_full || xfer);
  assign drop          = char_valid && hold_full && !xfer;
  assign hold_full_nxt = capture ? 1'b1 : (xfer ? 1'b0 : hold_full);

  // Datapath and flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold       <= 8'h00;
      hold_full  <= 1'b0;
      shreg      <= 8'h00;
      cnt        <= 3'd0;
      pixel      <= IDLE_PIXEL;
      char_ready <= 1'b1;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (flush) begin
        // Any byte offered in the flush cycle is discarded silently.
        hold_full  <= 1'b0;
        cnt        <= 3'd0;
        pixel      <= IDLE_PIXEL;
        char_ready <= 1'b1;
      end else begin
        if (capture) hold <= din;
        if (xfer) shreg <= hold;
        cnt        <= cnt_nxt;
        hold_full  <= hold_full_nxt;
        char_ready <= !hold_full_nxt;
        if (emit)        pixel <= blank ? 1'b0 : (emit_bit ^ invert);
        else if (starve) pixel <= IDLE_PIXEL;
      end
      // A new error event wins over a simultaneous clear.
      overrun  <= (drop   && !flush) || (overrun  && !clr_err);
      underrun <= (starve && !flush) || (underrun && !clr_err);
    end
  end

endmodule

// File: tb/tb_char_pixel_serializer.sv
module tb_char_pixel_serializer;

  localparam bit   LSB_FIRST  = 1'b1;
  localparam logic IDLE_PIXEL = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_ce = 1'b0;
  logic [7:0] rom_q = 8'h00;
  logic [7:0] patch_q = 8'h00;
  logic       patch = 1'b0;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       flush = 1'b0;
  logic       blank = 1'b0;
  logic       invert = 1'b0;
  logic       pixel;
  logic       overrun;
  logic       underrun;
  logic       clr_err = 1'b0;

  int total = 0;
  int bad = 0;

  char_pixel_serializer #(.LSB_FIRST(LSB_FIRST), .IDLE_PIXEL(IDLE_PIXEL)) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .rom_q(rom_q), .patch_q(patch_q),
    .patch(patch), .char_valid(char_valid), .char_ready(char_ready), .flush(flush),
    .blank(blank), .invert(invert), .pixel(pixel), .overrun(overrun),
    .underrun(underrun), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending pixels of the current character as a queue of bits, plus a
  // one-byte slot waiting behind it.
  logic q[$];
  logic [7:0] m_hold;
  logic m_full, m_pix, m_rdy, m_ovr, m_unr;

  task automatic load(input logic [7:0] b);
    for (int i = 0; i < 8; i++) q.push_back(LSB_FIRST ? b[i] : b[7-i]);
  endtask

  always @(posedge clk or posedge reset) begin
    logic [7:0] d;
    logic full0, xf, so, su, b;
    if (reset) begin
      q.delete();
      m_hold = 8'h00; m_full = 1'b0; m_pix = IDLE_PIXEL;
      m_rdy = 1'b1; m_ovr = 1'b0; m_unr = 1'b0;
    end else begin
      d = patch ? patch_q : rom_q;
      full0 = m_full; xf = 1'b0; so = 1'b0; su = 1'b0;
      if (flush) begin
        q.delete();
        m_full = 1'b0;
        m_pix = IDLE_PIXEL;
      end else begin
        if (pix_ce) begin
          if (q.size() == 0 && m_full) begin
            load(m_hold); m_full = 1'b0; xf = 1'b1;
          end
          if (q.size() > 0) begin
            b = q.pop_front();
            m_pix = blank ? 1'b0 : (b ^ invert);
            if (q.size() == 0 && m_full) begin
              load(m_hold); m_full = 1'b0; xf = 1'b1;
            end
          end else begin
            m_pix = IDLE_PIXEL;
            su = 1'b1;
          end
        end
        if (char_valid) begin
          if (!full0 || xf) begin
            m_hold = d; m_full = 1'b1;
          end else begin
            so = 1'b1;
          end
        end
      end
      m_ovr = so | (m_ovr & !clr_err);
      m_unr = su | (m_unr & !clr_err);
      m_rdy = !m_full;
    end
  end

  // Cycle-by-cycle comparison, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      chk("pixel",    {15'd0, pixel},      {15'd0, m_pix});
      chk("ready",    {15'd0, char_ready}, {15'd0, m_rdy});
      chk("overrun",  {15'd0, overrun},    {15'd0, m_ovr});
      chk("underrun", {15'd0, underrun},   {15'd0, m_unr});
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [7:0] b);
    rom_q = b; patch = 1'b0; char_valid = 1'b1;
    step();
    char_valid = 1'b0;
  endtask

  task automatic run_pix(input int n, output logic [15:0] acc);
    acc = 16'h0;
    for (int i = 0; i < n; i++) begin
      pix_ce = 1'b1;
      step();
      acc[i] = pixel;
    end
    pix_ce = 1'b0;
  endtask

  // pix_ce every 4th cycle; blank covers pixels blo..bhi
  task automatic slow_byte(input int blo, input int bhi, output logic [7:0] acc);
    acc = 8'h0;
    for (int i = 0; i < 32; i++) begin
      pix_ce = (i % 4 == 0);
      blank  = (i / 4 >= blo) && (i / 4 <= bhi);
      step();
      if (i % 4 == 0) acc[i/4] = pixel;
    end
    pix_ce = 1'b0;
    blank  = 1'b0;
  endtask

  initial begin
    logic [15:0] acc;
    logic [7:0] acc8;

    step(); step();
    chk("rst_pixel", {15'd0, pixel},      16'd0);
    chk("rst_ready", {15'd0, char_ready}, 16'd1);
    chk("rst_ovr",   {15'd0, overrun},    16'd0);
    chk("rst_unr",   {15'd0, underrun},   16'd0);
    reset = 1'b0;
    step();

    // 1: basic LSB-first shift, then starvation
    offer(8'h03);
    run_pix(8, acc);
    chk("t1_seq", {8'd0, acc[7:0]}, 16'h0003);
    pix_ce = 1'b1; step(); pix_ce = 1'b0;
    chk("t1_idle_px", {15'd0, pixel},    16'd0);
    chk("t1_unr",     {15'd0, underrun}, 16'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("t1_unr_clr", {15'd0, underrun}, 16'd0);

    // 2: source selection
    patch = 1'b1; patch_q = 8'hf8; rom_q = 8'hff; char_valid = 1'b1;
    step();
    char_valid = 1'b0;
    run_pix(8, acc);
    chk("t2_patch", {8'd0, acc[7:0]}, 16'h00f8);
    patch = 1'b0; patch_q = 8'hzz; rom_q = 8'h5a; char_valid = 1'b1;
    step();
    char_valid = 1'b0;
    run_pix(8, acc);
    chk("t2_rom", {8'd0, acc[7:0]}, 16'h005a);

    // 3: back-to-back, gapless
    offer(8'hfb);
    acc = 16'h0;
    for (int i = 0; i < 16; i++) begin
      pix_ce = 1'b1;
      char_valid = (i == 3);
      rom_q = 8'hab;
      step();
      acc[i] = pixel;
      if (i == 3) chk("t3_rdy_low",  {15'd0, char_ready}, 16'd0);
      if (i == 7) chk("t3_rdy_high", {15'd0, char_ready}, 16'd1);
    end
    pix_ce = 1'b0; char_valid = 1'b0;
    chk("t3_seq", acc, 16'habfb);

    // 4: overrun while holding, no pix_ce
    offer(8'h3c);
    offer(8'h55);
    chk("t4_ovr", {15'd0, overrun}, 16'd1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("t4_ovr_clr", {15'd0, overrun}, 16'd0);
    run_pix(8, acc);
    chk("t4_kept", {8'd0, acc[7:0]}, 16'h003c);

    // 5: slow pixel clock with invert, then blank mid-byte
    invert = 1'b1;
    offer(8'hff);
    slow_byte(9, 9, acc8);
    chk("t5_invert", {8'd0, acc8}, 16'h0000);
    invert = 1'b0;
    offer(8'hff);
    slow_byte(3, 4, acc8);
    chk("t5_blank", {8'd0, acc8}, 16'h00e7);

    // 6: flush at bit 3 with the holding register full
    offer(8'hff);
    run_pix(3, acc);
    offer(8'h81);
    flush = 1'b1; pix_ce = 1'b1; rom_q = 8'h77; char_valid = 1'b1;
    step();
    flush = 1'b0; pix_ce = 1'b0; char_valid = 1'b0;
    chk("t6_flush_px",  {15'd0, pixel},      16'd0);
    chk("t6_flush_rdy", {15'd0, char_ready}, 16'd1);
    chk("t6_flush_ovr", {15'd0, overrun},    16'd0);
    pix_ce = 1'b1; step(); pix_ce = 1'b0;
    chk("t6_idle_unr", {15'd0, underrun}, 16'd1);

    // Async reset mid-byte
    offer(8'hff);
    offer(8'h42);
    run_pix(2, acc);
    chk("t6_pre_rst", {15'd0, pixel}, 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_px",  {15'd0, pixel},      16'd0);
    chk("t6_rst_rdy", {15'd0, char_ready}, 16'd1);
    chk("t6_rst_ovr", {15'd0, overrun},    16'd0);
    chk("t6_rst_unr", {15'd0, underrun},   16'd0);
    step();
    reset = 1'b0;
    step();
    offer(8'hc5);
    run_pix(8, acc);
    chk("t6_after", {8'd0, acc[7:0]}, 16'h00c5);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/char_pixel_serializer.md
Name: char_pixel_serializer

Overview:
- Sits directly downstream of the character-ROM / ROM-patch pair in the Galaksija video path.
- Each cycle, selects the glyph byte from the patch stage (when `patch` is high) or from the character ROM.
- Buffers one byte in a holding register and serialises it into single pixels on a pixel-clock enable.
- Back-to-back characters are emitted gaplessly; overrun and underrun conditions are flagged for debug.

Parameters:
- LSB_FIRST, 1: 1 emits bit 0 first; 0 emits bit 7 first.
- IDLE_PIXEL, 1'b0: pixel level driven when no character data is available.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pix_ce  input  1  pixel clock enable; one pixel advances per cycle where high.
- rom_q  input  8  glyph byte from the character ROM.
- patch_q  input  8  glyph byte from the ROM-patch stage (may be undriven when patch low).
- patch  input  1  1 = use patch_q, 0 = use rom_q.
- char_valid  input  1  selected glyph byte is valid this cycle.
- char_ready  output  1  holding register can accept a byte.
- flush  input  1  synchronous line-start flush.
- blank  input  1  forces pixel output low; shifting continues.
- invert  input  1  XORs every emitted data bit (inverse video).
- pixel  output  1  registered serial pixel.
- overrun  output  1  sticky: a byte was dropped.
- underrun  output  1  sticky: pix_ce arrived with no data to emit.
- clr_err  input  1  synchronous clear of overrun/underrun.

Behaviour:
- Reset (async): state IDLE, hold_full=0, shift reg=0, cnt=0, pixel=IDLE_PIXEL, char_ready=1, overrun=0, underrun=0.
- Byte select: din = patch ? patch_q : rom_q. Sampled only when char_valid=1. patch_q is never read when patch=0, so X/Z on it is legal.
- char_ready is a register equal to !hold_full after each edge.
- Capture: char_valid && (!hold_full || xfer) -> hold<=din, hold_full<=1. Here xfer is the same-cycle hold-to-shifter transfer defined below.
- Drop: char_valid && hold_full && !xfer -> byte discarded, overrun<=1.
- States:
  - IDLE:
    - pix_ce && hold_full: xfer. Emit first bit of hold. Shifter <= hold; cnt<=1; hold_full<=0 (unless refilled the same cycle); -> SHIFT.
    - pix_ce && !hold_full: pixel<=IDLE_PIXEL; underrun<=1.
  - SHIFT:
    - pix_ce: emit bit[cnt] (order per LSB_FIRST); cnt<=cnt+1.
    - When the emitted bit is the 8th (cnt==7):
      - hold_full: xfer, so the next pix_ce emits bit 0 of the new byte (gapless); cnt<=0; stay SHIFT.
      - otherwise: -> IDLE.
- Emitted pixel value = blank ? 0 : (bit ^ invert).
  - Latency: pixel is registered and updates on the same edge where pix_ce is sampled high.
- No pix_ce: all state holds; captures and drops still occur.
- flush (priority over everything except reset):
  - Effects: hold_full<=0, cnt<=0, state<=IDLE, pixel<=IDLE_PIXEL, char_ready<=1.
  - Sticky flags are not changed. A char_valid in the same cycle is discarded with no overrun.
- clr_err: clears overrun/underrun. A simultaneous set wins (set has priority).
- Reset asserted mid-character: immediate return to reset values; the partial byte is lost.

Test Plan:
1. reset, then patch=0, rom_q=8'h03, char_valid one cycle, pix_ce every cycle, LSB_FIRST=1 -> pixel sequence 1,1,0,0,0,0,0,0, then IDLE_PIXEL with underrun=1.
2. Source selection: patch=1, patch_q=8'hf8, rom_q=8'hff -> pixels 0,0,0,1,1,1,1,1. With patch=0 and patch_q=8'hzz -> rom_q bits only, no X on pixel.
3. Back-to-back: load 8'hfb, and while shifting load 8'hab before the 8th pix_ce -> 16 contiguous pixels, no idle gap; char_ready low between capture and xfer.
4. Overrun: with hold_full=1 and no pix_ce, pulse char_valid with 8'h55 -> byte dropped, overrun=1, hold keeps old byte. clr_err -> overrun=0.
5. pix_ce every 4th cycle, invert=1, byte 8'hff -> eight 0 pixels, each held 4 cycles. blank=1 mid-byte -> pixel 0 while cnt still advances.
6. flush at bit 3 with hold full -> pixel=IDLE_PIXEL next edge, char_ready=1, state IDLE. Async reset mid-byte -> all outputs at reset values before the next clk edge.
